// File: rtl/win_detect_if.sv
// Grid-in / result-out bundle between the drop stage, win detector and display.
// The detector takes the slave side.
interface win_detect_if;
  logic [97:0] grid;
  logic        term;
  logic [1:0]  winner;
  logic [41:0] win_mask;
  logic        busy;

  modport master (output grid, input term, winner, win_mask, busy);
  modport slave  (input grid, output term, winner, win_mask, busy);
endinterface

// File: rtl/win_detect.sv
// Connect Four win/draw detector. Rescans the whole board whenever it changes,
// checking one (cell, direction) run per cycle in idx = cell*4 + dir order.
module win_detect #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  win_detect_if.slave bus
);

  localparam int CELLS    = ROWS * COLS;
  localparam int BW       = CELLS * 2;
  localparam int LAST_IDX = CELLS * 4 - 1;
  localparam int RW       = $clog2(ROWS);
  localparam int CW       = $clog2(COLS);
  localparam int BIW      = $clog2(BW);
  localparam int MIW      = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CW-1:0]    c_q, c_d;
  logic [1:0]       d_q, d_d;
  logic [BW-1:0]    prev_board;
  logic             term_q, term_d;
  logic [1:0]       winner_q, winner_d;
  logic [CELLS-1:0] mask_q, mask_d;
  logic             busy_q, busy_d;

  logic [BW-1:0]    board;
  logic             chg, full, in_bounds, run_hit;
  logic [1:0]       run_val;
  logic [CELLS-1:0] run_mask, occ;
  logic             unused_sel;

  assign board = bus.grid[BW-1:0];
  // The selection row above the board never influences the result.
  assign unused_sel = ^bus.grid[97:BW];
  assign chg = board != prev_board;

  genvar g;
  generate
    for (g = 0; g < CELLS; g++) begin : g_occ
      assign occ[g] = ^board[2*g +: 2];  // 01/10 occupied, 00/11 empty
    end
  endgenerate
  assign full = &occ;

  // Evaluate the run starting at (r_q, c_q) in direction d_q.
  always_comb begin
    int dr, dc, end_r, end_c, rr, cc;
    logic [1:0] cv;
    dr = (d_q == 2'd0) ? 0 : 1;
    case (d_q)
      2'd0, 2'd2: dc = 1;
      2'd1:       dc = 0;
      default:    dc = -1;
    endcase
    end_r     = int'(r_q) + (WIN_LEN - 1) * dr;
    end_c     = int'(c_q) + (WIN_LEN - 1) * dc;
    in_bounds = (end_r < ROWS) && (end_c >= 0) && (end_c < COLS);
    run_val   = board[BIW'(2 * (COLS * int'(r_q) + COLS - 1 - int'(c_q))) +: 2];
    run_hit   = in_bounds && (run_val[1] ^ run_val[0]);
    run_mask  = '0;
    for (int k = 0; k < WIN_LEN; k++) begin
      rr = int'(r_q) + k * dr;
      cc = int'(c_q) + k * dc;
      cv = 2'b00;
      if (in_bounds) begin
        cv = board[BIW'(2 * (COLS * rr + COLS - 1 - cc)) +: 2];
        run_mask[MIW'(rr * COLS + cc)] = 1'b1;
      end
      if (cv != run_val) run_hit = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    r_d      = r_q;
    c_d      = c_q;
    d_d      = d_q;
    term_d   = term_q;
    winner_d = winner_q;
    mask_d   = mask_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (chg) begin
          state_d = SCAN;
          idx_d   = '0;
          r_d     = '0;
          c_d     = '0;
          d_d     = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (chg) begin
          idx_d = '0;
          r_d   = '0;
          c_d   = '0;
          d_d   = '0;
        end else if (run_hit) begin
          state_d  = DONE;
          term_d   = 1'b1;
          winner_d = run_val;
          mask_d   = run_mask;
          busy_d   = 1'b0;
        end else if (idx_q == 8'(LAST_IDX)) begin
          busy_d   = 1'b0;
          mask_d   = '0;
          term_d   = full;
          winner_d = full ? 2'b11 : 2'b00;
          state_d  = full ? DONE : IDLE;
        end else begin
          idx_d = idx_q + 8'd1;
          d_d   = d_q + 2'd1;
          if (d_q == 2'd3) begin
            if (c_q == CW'(COLS - 1)) begin
              c_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (board == '0) begin
          state_d  = IDLE;
          term_d   = 1'b0;
          winner_d = 2'b00;
          mask_d   = '0;
        end else if (chg) begin
          // Result stays asserted until the rescan decides otherwise.
          state_d = SCAN;
          idx_d   = '0;
          r_d     = '0;
          c_d     = '0;
          d_d     = '0;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    prev_board <= board;
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      term_q   <= 1'b0;
      winner_q <= 2'b00;
      mask_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      r_q      <= r_d;
      c_q      <= c_d;
      d_q      <= d_d;
      term_q   <= term_d;
      winner_q <= winner_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.term     = term_q;
  assign bus.winner   = winner_q;
  assign bus.win_mask = mask_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_win_detect.sv
// Directed checks of win_detect: reset, each win shape, no-win, draw, restart and reset mid-scan.
module tb_win_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  win_detect_if bus ();
  win_detect dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle just past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [97:0] put(input logic [97:0] g, input int r, input int c,
                                      input logic [1:0] v);
    g[13 - 2*c + 14*r -: 2] = v;
    return g;
  endfunction

  task automatic chk_out(input string tag, input logic t, input logic [1:0] w,
                         input logic [41:0] m, input logic b);
    chk({tag, ".term"}, 64'(bus.term), 64'(t));
    chk({tag, ".winner"}, 64'(bus.winner), 64'(w));
    chk({tag, ".mask"}, 64'(bus.win_mask), 64'(m));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(b));
  endtask

  initial begin
    logic [97:0] g;
    // reset with an arbitrary grid
    bus.grid = {14'h2a5, 84'h123_4567_89ab_cdef_0123};
    rst = 1'b1;
    cyc(2);
    chk_out("reset", 1'b0, 2'b00, 42'h0, 1'b0);
    rst = 1'b0;
    cyc(5);
    chk("reset_hold.busy", 64'(bus.busy), 64'd0);

    // empty the board; it scans once, finds nothing, returns to idle
    bus.grid = '0;
    cyc(172);
    chk_out("empty", 1'b0, 2'b00, 42'h0, 1'b0);

    // horizontal win, idx 0
    bus.grid[13:6] = 8'b01010101;
    cyc(1);
    chk_out("horiz_n1", 1'b0, 2'b00, 42'h0, 1'b1);
    cyc(1);
    chk_out("horiz_n2", 1'b1, 2'b01, 42'h00000000F, 1'b0);
    cyc(3);
    chk("horiz_held.term", 64'(bus.term), 64'd1);

    // clearing the board leaves DONE in one cycle
    bus.grid = '0;
    cyc(1);
    chk_out("clear1", 1'b0, 2'b00, 42'h0, 1'b0);
    cyc(3);
    chk("clear1_idle.busy", 64'(bus.busy), 64'd0);

    // vertical win in col 6 rows 2-5, idx 81
    g = '0;
    for (int r = 2; r < 6; r++) g = put(g, r, 6, 2'b10);
    g = put(g, 0, 0, 2'b01);
    g = put(g, 0, 1, 2'b10);
    g = put(g, 1, 0, 2'b10);
    bus.grid = g;
    cyc(82);
    chk_out("vert_n82", 1'b0, 2'b00, 42'h0, 1'b1);
    cyc(1);
    chk_out("vert_n83", 1'b1, 2'b10, 42'h204_0810_0000, 1'b0);
    bus.grid = '0;
    cyc(2);

    // three in a row only: full scan, no result
    bus.grid[13:8] = 6'b010101;
    cyc(1);
    chk("nowin_n1.busy", 64'(bus.busy), 64'd1);
    cyc(167);
    chk_out("nowin_n168", 1'b0, 2'b00, 42'h0, 1'b1);
    cyc(1);
    chk_out("nowin_n169", 1'b0, 2'b00, 42'h0, 1'b0);

    // selection-row changes never start a scan
    bus.grid[97:84] = 14'h3fff;
    cyc(1);
    chk("selrow1.busy", 64'(bus.busy), 64'd0);
    bus.grid[97:84] = 14'h0155;
    cyc(2);
    chk("selrow2.busy", 64'(bus.busy), 64'd0);

    // full board with no 4-run: draw
    g = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        g = put(g, r, c, ((((c >> 1) & 1) ^ (r & 1)) != 0) ? 2'b10 : 2'b01);
    bus.grid = g;
    cyc(168);
    chk_out("draw_n168", 1'b0, 2'b00, 42'h0, 1'b1);
    cyc(1);
    chk_out("draw_n169", 1'b1, 2'b11, 42'h0, 1'b0);
    bus.grid[83:0] = '0;
    cyc(1);
    chk_out("clear2", 1'b0, 2'b00, 42'h0, 1'b0);
    cyc(2);

    // restart mid-scan: completing the bottom row at N+50
    bus.grid[13:8] = 6'b010101;
    cyc(50);
    bus.grid[7:6] = 2'b01;
    cyc(1);
    chk_out("restart_n51", 1'b0, 2'b00, 42'h0, 1'b1);
    cyc(1);
    chk_out("restart_n52", 1'b1, 2'b01, 42'h00000000F, 1'b0);

    // board write in DONE rescans with term held, then rst mid-scan
    bus.grid = put(bus.grid, 1, 0, 2'b10);
    cyc(1);
    chk_out("rescan_n1", 1'b1, 2'b01, 42'h00000000F, 1'b1);
    cyc(29);
    rst = 1'b1;
    cyc(1);
    chk_out("midrst_n31", 1'b0, 2'b00, 42'h0, 1'b0);
    rst = 1'b0;
    cyc(4);
    chk_out("after_rst", 1'b0, 2'b00, 42'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/win_detect.md
Name: win_detect

Overview:
- Downstream consumer of the Connect Four column-select/drop stage.
- Watches the 98-bit game grid that stage produces.
- Whenever the board contents change, sequentially scans all 42 cells in 4 directions for WIN_LEN equal, non-empty cells.
- Drives term back to the drop stage (blocks further drops), plus winner and a win-cell mask for the display stage.

Parameters:
ROWS, 6, board rows (row 0 = bottom)
COLS, 7, board columns (col 0 = leftmost)
WIN_LEN, 4, run length that wins; only defaults are required to be supported

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
grid  in  98  game grid; 7 rows of 14 bits, 2 bits per cell
term  out  1  game over (win or draw), held
winner  out  2  00 none, 01 player 0, 10 player 1, 11 draw
win_mask  out  42  one bit per winning cell, bit index row*7+col
busy  out  1  scan in progress

Behaviour:
- Cell encoding:
  - 00 empty, 01 player 0, 10 player 1, 11 treated as empty.
  - Cell (row r, col c) occupies grid[13-2c+14r -: 2], i.e. bits [13-2c+14r : 12-2c+14r].
  - Board region is grid[83:0]. grid[97:84] is the selection row; it is ignored completely, and changes there never trigger a scan.
- Change detect:
  - Register prev_board <= grid[83:0] every cycle.
  - Cycle N with grid[83:0] != prev_board raises a start request.
- States: IDLE, SCAN, DONE.
- Reset (rst=1 at edge):
  - term=0, winner=00, win_mask=0, busy=0, state=IDLE, idx=0, prev_board=grid[83:0].
  - Reset overrides everything, including mid-scan.
- IDLE:
  - On start request at cycle N: SCAN at N+1, idx=0, busy=1.
- SCAN:
  - One (cell, direction) pair evaluated per cycle.
  - idx in 0..167 = (r*7+c)*4 + d.
  - Directions: d0 (0,+1) right; d1 (+1,0) up; d2 (+1,+1) up-right; d3 (+1,-1) up-left.
  - Out-of-bounds runs are skipped as no-match; they still consume their cycle.
  - Match condition: all 4 cells equal and in {01,10}.
- Match found at idx i (evaluated in cycle N+1+i):
  - At the following edge: term=1, winner=cell value, win_mask = exactly the 4 run cells, busy=0, state=DONE.
  - The first match in idx order wins; later runs are not added to the mask.
- No match by idx 167:
  - Final result is visible at cycle N+169.
  - If all 42 cells are non-empty: term=1, winner=11, win_mask=0, state=DONE.
  - Otherwise: term=0, winner=00, win_mask=0, state=IDLE.
  - busy=0 in both cases.
- Board change during SCAN: restart at idx=0 on the next cycle. busy stays 1; outputs keep prior values.
- DONE:
  - Outputs held.
  - If grid[83:0] becomes all-zero (new game/reset by drop stage): term=0, winner=00, win_mask=0, state=IDLE next cycle.
  - Any other board change in DONE (e.g. AI write): rescan as in IDLE. term stays 1 until the rescan completes.
- Outputs are registered only; term never glitches combinationally.
- idx is 8 bits, saturates at 167; no wrap.
- Implementation: r/c/d counters or a divide-free decomposition are both acceptable, provided the ordering matches idx.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary grid -> term=0, winner=00, win_mask=0, busy=0. With the grid held, no scan starts afterwards.
- Horizontal: at cycle N set grid[13:6]=8'b01010101 (row 0, cols 0-3 = player 0) -> busy=1 at N+1; term=1, winner=01, win_mask=42'h00000000F at N+2 (idx 0).
- Vertical: col 6, rows 2-5 = 10 (bits 29:28, 43:42, 57:56, 71:70), other cells scattered non-winning -> term=1, winner=10, win_mask bits 20,27,34,41 set, at N+83 (idx 81).
- No win / selection-row only: three-in-a-row only -> busy high N+1..N+168, term=0 at N+169. Toggling grid[97:84] only -> busy never asserts.
- Draw and clear: full 42-cell board with no 4-run -> term=1, winner=11 at N+169. Then grid[83:0]=0 -> term=0, winner=00 one cycle later.
- Restart/reset mid-scan: change the board at N+50 to add a bottom-row win -> result at N+52. Separately, rst at N+30 -> all outputs 0 at N+31, state IDLE.
